// File: rtl/xoodoo_sca_pkg.sv
// Shared definitions for the masked Xoodoo round controller: widths,
// round-constant table and FSM encoding.
package xoodoo_sca_pkg;

    localparam int STATE_W    = 384;
    localparam int LANE_W     = 32;
    localparam int NUM_LANES  = STATE_W / LANE_W;
    localparam int MAX_ROUNDS = 12;

    // Round constants for Xoodoo[12]; a reduced run of n rounds uses the last n entries.
    localparam logic [LANE_W-1:0] RC [MAX_ROUNDS] = '{
        32'h0000_0058, 32'h0000_0038, 32'h0000_03C0, 32'h0000_00D0,
        32'h0000_0120, 32'h0000_0014, 32'h0000_0060, 32'h0000_002C,
        32'h0000_0380, 32'h0000_00F0, 32'h0000_01A0, 32'h0000_0012
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/xoodoo_ctrl_sca_rc_rom.sv
// Combinational round-index to round-constant lookup; out-of-range indices read 0.
module xoodoo_rc_rom
    import xoodoo_sca_pkg::*;
(
    input  logic [3:0]        idx,
    output logic [LANE_W-1:0] rc
);

    // Table lookup guarded against the four unused index codes.
    always_comb begin
        rc = '0;
        if (int'(idx) < MAX_ROUNDS) begin
            rc = RC[idx];
        end
    end

endmodule

// File: rtl/xoodoo_ctrl_sca.sv
// Sequencing controller for one external DOM Xoodoo round instance.
// Captures two shares, iterates N rounds (one per PRNG word), returns the
// output shares through a valid/ready handshake. Shares are only ever
// multiplexed, never combined with each other.
module xoodoo_ctrl_sca
    import xoodoo_sca_pkg::*;
#(
    parameter int MAX_ROUNDS = xoodoo_sca_pkg::MAX_ROUNDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [3:0]         num_rounds,
    input  logic [STATE_W-1:0] state_in_0,
    input  logic [STATE_W-1:0] state_in_1,
    input  logic               rdi_valid,
    output logic               rdi_ready,
    output logic [STATE_W-1:0] rnd_in_0,
    output logic [STATE_W-1:0] rnd_in_1,
    output logic               rnd_rdi_en,
    output logic [LANE_W-1:0]  rnd_rconst,
    input  logic [STATE_W-1:0] rnd_out_0,
    input  logic [STATE_W-1:0] rnd_out_1,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [STATE_W-1:0] state_out_0,
    output logic [STATE_W-1:0] state_out_1,
    output logic               busy
);

    localparam logic [3:0] MAX_R4 = 4'(MAX_ROUNDS);

    fsm_state_t         state_reg;
    logic [STATE_W-1:0] st0_reg;
    logic [STATE_W-1:0] st1_reg;
    logic [3:0]         nr_reg;
    logic [3:0]         idx_reg;
    logic               first_reg;
    logic               start_ready_reg;
    logic               rdi_ready_reg;
    logic               done_valid_reg;
    logic               busy_reg;

    logic [3:0]         nr_next;
    logic [3:0]         rc_idx;
    logic [LANE_W-1:0]  rc_word;
    logic               use_feedback;

    // Out-of-range round counts fall back to the full permutation.
    assign nr_next = (num_rounds == 4'd0 || num_rounds > MAX_R4) ? MAX_R4 : num_rounds;

    // Reduced-round runs use the tail of the constant table; idx < nr keeps this in 0..11.
    assign rc_idx = MAX_R4 - nr_reg + idx_reg;

    xoodoo_rc_rom u_rc_rom (
        .idx (rc_idx),
        .rc  (rc_word)
    );

    // Controller FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            st0_reg         <= '0;
            st1_reg         <= '0;
            nr_reg          <= '0;
            idx_reg         <= '0;
            first_reg       <= 1'b0;
            start_ready_reg <= 1'b1;
            rdi_ready_reg   <= 1'b0;
            done_valid_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_valid) begin
                        st0_reg         <= state_in_0;
                        st1_reg         <= state_in_1;
                        nr_reg          <= nr_next;
                        idx_reg         <= 4'd0;
                        first_reg       <= 1'b1;
                        state_reg       <= ST_RUN;
                        start_ready_reg <= 1'b0;
                        rdi_ready_reg   <= 1'b1;
                        busy_reg        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Without a PRNG word the cycle is a pure stall.
                    if (rdi_valid) begin
                        first_reg <= 1'b0;
                        idx_reg   <= idx_reg + 4'd1;
                        if (idx_reg == nr_reg - 4'd1) begin
                            state_reg      <= ST_DONE;
                            rdi_ready_reg  <= 1'b0;
                            done_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        state_reg       <= ST_IDLE;
                        done_valid_reg  <= 1'b0;
                        busy_reg        <= 1'b0;
                        start_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    start_ready_reg <= 1'b1;
                    rdi_ready_reg   <= 1'b0;
                    done_valid_reg  <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = start_ready_reg;
    assign rdi_ready   = rdi_ready_reg;
    assign done_valid  = done_valid_reg;
    assign busy        = busy_reg;
    assign rnd_rdi_en  = rdi_ready_reg & rdi_valid;
    assign rnd_rconst  = rdi_ready_reg ? rc_word : '0;

    // Round feedback is taken only after the captured shares have been loaded once.
    assign use_feedback = rdi_ready_reg & ~first_reg;

    // Per-lane share muxing; each share is routed independently so no cross-share net exists.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign rnd_in_0[gi*LANE_W +: LANE_W] =
                use_feedback ? rnd_out_0[gi*LANE_W +: LANE_W] : st0_reg[gi*LANE_W +: LANE_W];
            assign rnd_in_1[gi*LANE_W +: LANE_W] =
                use_feedback ? rnd_out_1[gi*LANE_W +: LANE_W] : st1_reg[gi*LANE_W +: LANE_W];
            assign state_out_0[gi*LANE_W +: LANE_W] =
                done_valid_reg ? rnd_out_0[gi*LANE_W +: LANE_W] : '0;
            assign state_out_1[gi*LANE_W +: LANE_W] =
                done_valid_reg ? rnd_out_1[gi*LANE_W +: LANE_W] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_xoodoo_ctrl_sca.sv
// Self-checking bench: a behavioural masked round stands in for the external
// round instance; results are compared against an unmasked Xoodoo model.
module tb_xoodoo_ctrl_sca;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [3:0]   num_rounds = 4'd0;
    logic [383:0] state_in_0 = '0;
    logic [383:0] state_in_1 = '0;
    logic         rdi_valid = 1'b0;
    logic         rdi_ready;
    logic [383:0] rnd_in_0;
    logic [383:0] rnd_in_1;
    logic         rnd_rdi_en;
    logic [31:0]  rnd_rconst;
    logic [383:0] rout_0;
    logic [383:0] rout_1;
    logic         done_valid;
    logic         done_ready = 1'b0;
    logic [383:0] state_out_0;
    logic [383:0] state_out_1;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int leak_viol = 0;
    int rdi_en_viol = 0;
    int rc_hold_viol = 0;
    logic [31:0]  rc_seen [$];
    logic [383:0] mask_next;
    logic [31:0]  rc_ref [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                  32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

    xoodoo_ctrl_sca dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .num_rounds(num_rounds),
        .state_in_0(state_in_0), .state_in_1(state_in_1),
        .rdi_valid(rdi_valid), .rdi_ready(rdi_ready),
        .rnd_in_0(rnd_in_0), .rnd_in_1(rnd_in_1), .rnd_rdi_en(rnd_rdi_en),
        .rnd_rconst(rnd_rconst), .rnd_out_0(rout_0), .rnd_out_1(rout_1),
        .done_valid(done_valid), .done_ready(done_ready),
        .state_out_0(state_out_0), .state_out_1(state_out_1), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
        return (v << r) | (v >> (32 - r));
    endfunction

    function automatic logic [383:0] rand384();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Unmasked Xoodoo round: theta, rho-west, iota, chi, rho-east.
    function automatic logic [383:0] xround(input logic [383:0] a, input logic [31:0] rc);
        logic [31:0] l [3][4];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [31:0] t [4];
        logic [31:0] b [3][4];
        logic [383:0] r;
        for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) l[y][x] = a[(y*4+x)*32 +: 32];
        for (int x = 0; x < 4; x++) p[x] = l[0][x] ^ l[1][x] ^ l[2][x];
        for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) l[y][x] ^= e[x];
        for (int x = 0; x < 4; x++) t[x] = l[1][x];
        for (int x = 0; x < 4; x++) l[1][x] = t[(x+3)%4];
        for (int x = 0; x < 4; x++) l[2][x] = rotl(l[2][x], 11);
        l[0][0] ^= rc;
        for (int x = 0; x < 4; x++) begin
            b[0][x] = ~l[1][x] & l[2][x];
            b[1][x] = ~l[2][x] & l[0][x];
            b[2][x] = ~l[0][x] & l[1][x];
        end
        for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) l[y][x] ^= b[y][x];
        for (int x = 0; x < 4; x++) l[1][x] = rotl(l[1][x], 1);
        for (int x = 0; x < 4; x++) t[x] = l[2][x];
        for (int x = 0; x < 4; x++) l[2][x] = rotl(t[(x+2)%4], 8);
        for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) r[(y*4+x)*32 +: 32] = l[y][x];
        return r;
    endfunction

    // Reference: Xoodoo[n] on the unmasked state, with the effective round-count rule.
    function automatic logic [383:0] xperm(input logic [383:0] s, input logic [3:0] n);
        int ne;
        ne = (n == 0 || n > 12) ? 12 : int'(n);
        for (int i = 0; i < ne; i++) s = xround(s, rc_ref[12 - ne + i]);
        return s;
    endfunction

    function automatic int eff_rounds(input logic [3:0] n);
        return (n == 0 || n > 12) ? 12 : int'(n);
    endfunction

    // Behavioural masked round instance (fresh output mask every enabled cycle).
    always @(posedge clk) begin
        mask_next <= rand384();
        if (rnd_rdi_en) begin
            rout_0 <= xround(rnd_in_0 ^ rnd_in_1, rnd_rconst) ^ mask_next;
            rout_1 <= mask_next;
        end
    end

    // Leakage monitor: result ports dark outside DONE, no PRNG enable outside RUN.
    always @(negedge clk) begin
        if (!done_valid && (state_out_0 !== '0 || state_out_1 !== '0)) leak_viol <= leak_viol + 1;
        if (rnd_rdi_en && !(busy && !done_valid)) leak_viol <= leak_viol + 1;
    end

    task automatic issue_start(input logic [383:0] s0, input logic [383:0] s1, input logic [3:0] n);
        @(negedge clk);
        start_valid = 1'b1; state_in_0 = s0; state_in_1 = s1; num_rounds = n;
        for (int i = 0; i < 50 && !start_ready; i++) @(negedge clk);
        checks++;
        if (start_ready !== 1'b1) begin
            errors++; $display("FAIL start_timeout: start_ready=%b required 1", start_ready);
        end
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic run_to_done(input int stall_pct, output logic [383:0] res,
                               output int cyc, output int stalls);
        logic go;
        logic prev_stall;
        logic [31:0] prev_rc;
        rc_seen.delete(); cyc = 0; stalls = 0; prev_stall = 1'b0; prev_rc = '0;
        for (int i = 0; i < 400; i++) begin
            if (done_valid) break;
            cyc++;
            if (prev_stall && rnd_rconst !== prev_rc) rc_hold_viol++;
            prev_rc = rnd_rconst;
            go = ($urandom_range(0, 99) >= stall_pct);
            rdi_valid = go;
            #1;
            if (rnd_rdi_en !== go || rdi_ready !== 1'b1) rdi_en_viol++;
            if (go) rc_seen.push_back(rnd_rconst); else stalls++;
            prev_stall = !go;
            @(negedge clk);
        end
        rdi_valid = 1'b0;
        checks++;
        if (done_valid !== 1'b1) begin
            errors++; $display("FAIL done_timeout: done_valid=%b required 1", done_valid);
        end
        res = state_out_0 ^ state_out_1;
    endtask

    task automatic finish_done();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdi_valid = 1'b1; done_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_ready, done_valid, rdi_ready, rnd_rdi_en, busy} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags: got %b required 10000",
                               {start_ready, done_valid, rdi_ready, rnd_rdi_en, busy});
        end
        checks++;
        if (rnd_rconst !== 32'h0 || state_out_0 !== '0 || state_out_1 !== '0 ||
            rnd_in_0 !== '0 || rnd_in_1 !== '0) begin
            errors++; $display("FAIL reset_data: rconst=%h required 0, data ports not all zero", rnd_rconst);
        end
        rst_n = 1'b1; rdi_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: start_ready=%b busy=%b required 1 0", start_ready, busy);
        end
        $display("reset: done");
    endtask

    task automatic test_full_perm();
        logic [383:0] r;
        logic [383:0] res;
        int cyc;
        int st;
        r = rand384();
        issue_start(r, r, 4'd12);
        run_to_done(0, res, cyc, st);
        checks++;
        if (cyc != 12) begin errors++; $display("FAIL full_cycles: got %0d required 12", cyc); end
        checks++;
        if (res !== xperm('0, 4'd12)) begin
            errors++; $display("FAIL full_result: got %h required %h", res[63:0], xperm('0, 4'd12) >> 0);
        end
        checks++;
        for (int i = 0; i < 12; i++) begin
            if (i >= rc_seen.size() || rc_seen[i] !== rc_ref[i]) begin
                errors++; $display("FAIL full_rconst[%0d]: got %h required %h", i,
                                   (i < rc_seen.size()) ? rc_seen[i] : 32'hx, rc_ref[i]);
                break;
            end
        end
        finish_done();
        $display("full_perm: cycles=%0d result=%h", cyc, res[31:0]);
    endtask

    task automatic test_reduced();
        logic [31:0] exp6 [6] = '{32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};
        logic [383:0] s0;
        logic [383:0] s1;
        logic [383:0] res;
        int cyc;
        int st;
        s0 = rand384(); s1 = rand384();
        issue_start(s0, s1, 4'd6);
        run_to_done(0, res, cyc, st);
        checks++;
        if (cyc != 6) begin errors++; $display("FAIL reduced_cycles: got %0d required 6", cyc); end
        checks++;
        if (res !== xperm(s0 ^ s1, 4'd6)) begin
            errors++; $display("FAIL reduced_result: got %h required %h", res[63:0], xperm(s0 ^ s1, 4'd6) >> 0);
        end
        checks++;
        if (rc_seen.size() != 6) begin
            errors++; $display("FAIL reduced_rconst_count: got %0d required 6", rc_seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (rc_seen[i] !== exp6[i]) begin
                    errors++; $display("FAIL reduced_rconst[%0d]: got %h required %h", i, rc_seen[i], exp6[i]);
                    break;
                end
            end
        end
        finish_done();
        $display("reduced: cycles=%0d result=%h", cyc, res[31:0]);
    endtask

    task automatic test_stalls();
        logic [383:0] s0;
        logic [383:0] s1;
        logic [383:0] res;
        int cyc;
        int st;
        rc_hold_viol = 0;
        s0 = rand384(); s1 = rand384();
        issue_start(s0, s1, 4'd12);
        run_to_done(50, res, cyc, st);
        checks++;
        if (cyc != 12 + st) begin
            errors++; $display("FAIL stall_cycles: got %0d required %0d", cyc, 12 + st);
        end
        checks++;
        if (res !== xperm(s0 ^ s1, 4'd12)) begin
            errors++; $display("FAIL stall_result: got %h required %h", res[63:0], xperm(s0 ^ s1, 4'd12) >> 0);
        end
        checks++;
        if (rc_hold_viol != 0) begin
            errors++; $display("FAIL stall_rconst_hold: got %0d changes required 0", rc_hold_viol);
        end
        finish_done();
        $display("stalls: cycles=%0d stalls=%0d", cyc, st);
    endtask

    task automatic test_saturation();
        logic [3:0] nl [2] = '{4'd0, 4'd15};
        logic [383:0] s0;
        logic [383:0] s1;
        logic [383:0] res;
        int cyc;
        int st;
        for (int k = 0; k < 2; k++) begin
            s0 = rand384(); s1 = rand384();
            issue_start(s0, s1, nl[k]);
            run_to_done(0, res, cyc, st);
            checks++;
            if (cyc != eff_rounds(nl[k])) begin
                errors++; $display("FAIL sat_cycles n=%0d: got %0d required %0d", nl[k], cyc, eff_rounds(nl[k]));
            end
            checks++;
            if (res !== xperm(s0 ^ s1, nl[k])) begin
                errors++; $display("FAIL sat_result n=%0d: got %h required %h", nl[k], res[63:0],
                                   xperm(s0 ^ s1, nl[k]) >> 0);
            end
            finish_done();
            $display("saturation: n=%0d cycles=%0d", nl[k], cyc);
        end
    endtask

    task automatic test_back_pressure();
        logic [383:0] s0;
        logic [383:0] s1;
        logic [383:0] n0;
        logic [383:0] n1;
        logic [383:0] res;
        logic [383:0] snap0;
        logic [383:0] snap1;
        int cyc;
        int st;
        s0 = rand384(); s1 = rand384();
        issue_start(s0, s1, 4'd3);
        run_to_done(0, res, cyc, st);
        checks++;
        if (res !== xperm(s0 ^ s1, 4'd3)) begin
            errors++; $display("FAIL bp_result: got %h required %h", res[63:0], xperm(s0 ^ s1, 4'd3) >> 0);
        end
        snap0 = state_out_0; snap1 = state_out_1;
        n0 = rand384(); n1 = rand384();
        start_valid = 1'b1; state_in_0 = n0; state_in_1 = n1; num_rounds = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done_valid !== 1'b1 || state_out_0 !== snap0 || state_out_1 !== snap1 || start_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: done_valid=%b start_ready=%b required 1 0, outputs stable=%b",
                                   i, done_valid, start_ready, (state_out_0 === snap0) && (state_out_1 === snap1));
            end
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checks++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: done_valid=%b start_ready=%b required 0 1", done_valid, start_ready);
        end
        @(negedge clk);
        start_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_pending_start: busy=%b required 1", busy); end
        run_to_done(0, res, cyc, st);
        checks++;
        if (res !== xperm(n0 ^ n1, 4'd2) || cyc != 2) begin
            errors++; $display("FAIL bp_second: cycles=%0d required 2, result=%h required %h", cyc, res[63:0],
                               xperm(n0 ^ n1, 4'd2) >> 0);
        end
        finish_done();
        $display("back_pressure: second run cycles=%0d", cyc);
    endtask

    task automatic test_reset_mid();
        logic [383:0] s0;
        logic [383:0] s1;
        logic [383:0] res;
        int cyc;
        int st;
        s0 = rand384(); s1 = rand384();
        issue_start(s0, s1, 4'd12);
        rdi_valid = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, done_valid, rdi_ready, rnd_rdi_en, busy} !== 5'b10000 || rnd_rconst !== 32'h0) begin
            errors++; $display("FAIL midreset_flags: got %b rconst=%h required 10000 0",
                               {start_ready, done_valid, rdi_ready, rnd_rdi_en, busy}, rnd_rconst);
        end
        checks++;
        if (rnd_in_0 !== '0 || rnd_in_1 !== '0 || state_out_0 !== '0 || state_out_1 !== '0) begin
            errors++; $display("FAIL midreset_data: rnd_in/state_out not zero, rnd_in_0=%h required 0", rnd_in_0[63:0]);
        end
        rdi_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s0 = rand384(); s1 = rand384();
        issue_start(s0, s1, 4'd12);
        run_to_done(0, res, cyc, st);
        checks++;
        if (res !== xperm(s0 ^ s1, 4'd12) || cyc != 12) begin
            errors++; $display("FAIL midreset_rerun: cycles=%0d required 12, result=%h required %h", cyc,
                               res[63:0], xperm(s0 ^ s1, 4'd12) >> 0);
        end
        finish_done();
        $display("reset_mid: rerun cycles=%0d", cyc);
    endtask

    task automatic test_leakage();
        @(negedge clk);
        checks++;
        if (leak_viol != 0) begin
            errors++; $display("FAIL leakage: got %0d violations required 0", leak_viol);
        end
        checks++;
        if (rdi_en_viol != 0) begin
            errors++; $display("FAIL rdi_en_follow: got %0d violations required 0", rdi_en_viol);
        end
        $display("leakage: monitor violations=%0d", leak_viol);
    endtask

    initial begin
        test_reset();
        test_full_perm();
        test_reduced();
        test_stalls();
        test_saturation();
        test_back_pressure();
        test_reset_mid();
        test_leakage();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
